// File: rtl/soc_bus_decoder.sv
// rtl/soc_bus_decoder.sv - address decoder and response mux between one bus master and three slaves
module soc_bus_decoder #(
    parameter logic [31:0] S0_BASE = 32'h0000_0000,
    parameter logic [31:0] S0_MASK = 32'hF000_0000,
    parameter logic [31:0] S1_BASE = 32'h1000_0000,
    parameter logic [31:0] S1_MASK = 32'hFFFF_FFF0,
    parameter logic [31:0] S2_BASE = 32'h2000_0000,
    parameter logic [31:0] S2_MASK = 32'hFFFF_FFF0,
    parameter int          TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] m_address,
    input  logic [31:0] m_wdata,
    input  logic [3:0]  m_wsel,
    input  logic        m_valid,
    output logic [31:0] m_rdata,
    output logic        m_ready,
    output logic        m_error,
    output logic [31:0] s0_address,
    output logic [31:0] s0_wdata,
    output logic [3:0]  s0_wsel,
    output logic        s0_valid,
    input  logic [31:0] s0_rdata,
    input  logic        s0_ready,
    input  logic        s0_error,
    output logic [31:0] s1_address,
    output logic [31:0] s1_wdata,
    output logic [3:0]  s1_wsel,
    output logic        s1_valid,
    input  logic [31:0] s1_rdata,
    input  logic        s1_ready,
    input  logic        s1_error,
    output logic [31:0] s2_address,
    output logic [31:0] s2_wdata,
    output logic [3:0]  s2_wsel,
    output logic        s2_valid,
    input  logic [31:0] s2_rdata,
    input  logic        s2_ready,
    input  logic        s2_error
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Last wait-counter value before the access is abandoned.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    logic [1:0]  r_sel;
    logic [7:0]  r_wait;
    logic [2:0]  r_svalid;
    logic        r_ready;
    logic        r_error;
    logic [31:0] r_rdata;

    logic [2:0]  w_hit;
    logic [1:0]  w_dec_sel;
    logic        w_sel_ready;
    logic        w_sel_error;
    logic [31:0] w_sel_rdata;

    // Request fields go to every slave; only the valid strobe is steered.
    assign s0_address = m_address;
    assign s0_wdata   = m_wdata;
    assign s0_wsel    = m_wsel;
    assign s1_address = m_address;
    assign s1_wdata   = m_wdata;
    assign s1_wsel    = m_wsel;
    assign s2_address = m_address;
    assign s2_wdata   = m_wdata;
    assign s2_wsel    = m_wsel;

    assign s0_valid = r_svalid[0];
    assign s1_valid = r_svalid[1];
    assign s2_valid = r_svalid[2];

    assign m_rdata = r_rdata;
    assign m_ready = r_ready;
    assign m_error = r_error;

    // Address decode; the lowest-numbered matching slave wins overlaps.
    always_comb begin
        w_hit[0]  = (m_address & S0_MASK) == S0_BASE;
        w_hit[1]  = (m_address & S1_MASK) == S1_BASE;
        w_hit[2]  = (m_address & S2_MASK) == S2_BASE;
        w_dec_sel = 2'd0;
        if (w_hit[0]) begin
            w_dec_sel = 2'd0;
        end else if (w_hit[1]) begin
            w_dec_sel = 2'd1;
        end else if (w_hit[2]) begin
            w_dec_sel = 2'd2;
        end
    end

    // Response of the latched slave only; the others are never looked at.
    always_comb begin
        w_sel_ready = 1'b0;
        w_sel_error = 1'b0;
        w_sel_rdata = 32'h0;
        case (r_sel)
            2'd0: begin
                w_sel_ready = s0_ready;
                w_sel_error = s0_error;
                w_sel_rdata = s0_rdata;
            end
            2'd1: begin
                w_sel_ready = s1_ready;
                w_sel_error = s1_error;
                w_sel_rdata = s1_rdata;
            end
            2'd2: begin
                w_sel_ready = s2_ready;
                w_sel_error = s2_error;
                w_sel_rdata = s2_rdata;
            end
            default: begin
                w_sel_ready = 1'b0;
                w_sel_error = 1'b0;
                w_sel_rdata = 32'h0;
            end
        endcase
    end

    // Transaction FSM with registered slave strobes and master response.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_sel    <= 2'd0;
            r_wait   <= 8'd0;
            r_svalid <= 3'b000;
            r_ready  <= 1'b0;
            r_error  <= 1'b0;
            r_rdata  <= 32'h0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_ready <= 1'b0;
                    r_error <= 1'b0;
                    if (m_valid) begin
                        if (|w_hit) begin
                            r_sel    <= w_dec_sel;
                            r_svalid <= 3'(3'b001 << w_dec_sel);
                            r_wait   <= 8'd0;
                            r_state  <= ACCESS;
                        end else begin
                            r_error <= 1'b1;
                            r_state <= RESP;
                        end
                    end
                end
                ACCESS: begin
                    if (!m_valid) begin
                        // Master abandoned the request: drop it silently.
                        r_svalid <= 3'b000;
                        r_state  <= IDLE;
                    end else if (w_sel_ready || w_sel_error) begin
                        r_rdata  <= w_sel_rdata;
                        r_ready  <= w_sel_ready & ~w_sel_error;
                        r_error  <= w_sel_error;
                        r_svalid <= 3'b000;
                        r_state  <= RESP;
                    end else if (r_wait == WAIT_LAST) begin
                        r_rdata  <= 32'h0;
                        r_error  <= 1'b1;
                        r_svalid <= 3'b000;
                        r_state  <= RESP;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                RESP: begin
                    r_ready <= 1'b0;
                    r_error <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_svalid <= 3'b000;
                    r_ready  <= 1'b0;
                    r_error  <= 1'b0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

endmodule
